// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// supported opcodes and ALU operation encodings.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } mc_state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_legal_opc(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_mc_out_decode.sv
// Combinational strobe decoder: maps current state, latched opcode, ALU zero
// flag and memory handshake onto the datapath strobes. Also flags the cycle
// in which an instruction completes.
module mc_out_decode
  import multicycle_control_pkg::*;
(
  input  mc_state_t   i_state,
  input  logic [6:0]  i_opc,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_pc_src,
  output logic        o_ir_write,
  output logic        o_alu_src,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_branch,
  output logic [1:0]  o_alu_op,
  output logic        o_instr_end
);

  // Strobes default low; each state raises only what it owns.
  always_comb begin
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_ir_write   = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_branch     = 1'b0;
    o_alu_op     = ALUOP_ADD;
    o_instr_end  = 1'b0;
    unique case (i_state)
      S_FETCH: begin
        o_mem_read = 1'b1;
        o_ir_write = i_mem_ready;
        o_pc_write = i_mem_ready;
      end
      S_EXEC: begin
        if (i_opc == OPC_RTYPE) begin
          o_alu_op = ALUOP_FUNCT;
        end else if (i_opc == OPC_BRANCH) begin
          o_alu_op    = ALUOP_SUB;
          o_branch    = 1'b1;
          o_pc_src    = 1'b1;
          o_pc_write  = i_zero;
          o_instr_end = 1'b1;
        end else begin
          o_alu_op  = ALUOP_ADD;
          o_alu_src = 1'b1;
        end
      end
      S_MEM: begin
        if (i_opc == OPC_LOAD) begin
          o_mem_read = 1'b1;
        end else begin
          o_mem_write = 1'b1;
          o_instr_end = i_mem_ready;
        end
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (i_opc == OPC_LOAD);
        o_instr_end  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: holds state, latched opcode and the sticky
// illegal flag; strobe generation lives in mc_out_decode.
// Optional feature: define MC_PERF_CNT_EN to add the retired-instruction
// counter output instr_cnt.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  opc,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PcWrite,
  output logic        PcSrc,
  output logic        IrWrite,
  output logic        ALUsrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  AluOp,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  mc_state_t  r_state;
  logic [6:0] r_opc;
  logic       r_illegal;
  logic       w_instr_end;

  mc_out_decode u_out_decode (
    .i_state      (r_state),
    .i_opc        (r_opc),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_write   (PcWrite),
    .o_pc_src     (PcSrc),
    .o_ir_write   (IrWrite),
    .o_alu_src    (ALUsrc),
    .o_mem_to_reg (MemToReg),
    .o_reg_write  (RegWrite),
    .o_mem_read   (MemRead),
    .o_mem_write  (MemWrite),
    .o_branch     (Branch),
    .o_alu_op     (AluOp),
    .o_instr_end  (w_instr_end)
  );

  // Sequencing FSM; every completed instruction re-samples en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_opc     <= 7'd0;
      r_illegal <= 1'b0;
    end else if (w_instr_end) begin
      r_state <= en ? S_FETCH : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (en) r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opc <= opc;
          if (is_legal_opc(opc)) begin
            r_state <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end
        end
        S_EXEC:   r_state <= (r_opc == OPC_RTYPE) ? S_WB : S_MEM;
        S_MEM:    if (mem_ready) r_state <= S_WB;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign state   = r_state;

`ifdef MC_PERF_CNT_EN
  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (w_instr_end) begin
      instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  // CNT_W only sizes the optional counter; keep a sanity guard on it.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  opc;
  logic        zero;
  logic        mem_ready;
  logic        PcWrite, PcSrc, IrWrite, ALUsrc, MemToReg, RegWrite;
  logic        MemRead, MemWrite, Branch, illegal;
  logic [1:0]  AluOp;
  logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [3:0]  instr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  // {PcWrite,PcSrc,IrWrite,ALUsrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,AluOp}
  localparam logic [10:0] ST_NONE      = 11'b000_000_000_00;
  localparam logic [10:0] ST_FETCH_RDY = 11'b101_000_100_00;
  localparam logic [10:0] ST_FETCH_WT  = 11'b000_000_100_00;
  localparam logic [10:0] ST_EXEC_R    = 11'b000_000_000_10;
  localparam logic [10:0] ST_EXEC_LS   = 11'b000_100_000_00;
  localparam logic [10:0] ST_WB_R      = 11'b000_001_000_00;
  localparam logic [10:0] ST_MEM_LD    = 11'b000_000_100_00;
  localparam logic [10:0] ST_WB_LD     = 11'b000_011_000_00;
  localparam logic [10:0] ST_EXEC_BR1  = 11'b110_000_001_01;
  localparam logic [10:0] ST_EXEC_BR0  = 11'b010_000_001_01;
  localparam logic [10:0] ST_MEM_ST    = 11'b000_000_010_00;

  multicycle_control #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .opc       (opc),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PcWrite   (PcWrite),
    .PcSrc     (PcSrc),
    .IrWrite   (IrWrite),
    .ALUsrc    (ALUsrc),
    .MemToReg  (MemToReg),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Branch    (Branch),
    .AluOp     (AluOp),
    .illegal   (illegal),
    .state     (state)
`ifdef MC_PERF_CNT_EN
    , .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] strb();
    return {PcWrite, PcSrc, IrWrite, ALUsrc, MemToReg, RegWrite,
            MemRead, MemWrite, Branch, AluOp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp_state, input logic [10:0] exp_strb);
    chk({tag, ".state"}, 32'(state), 32'(exp_state));
    chk({tag, ".strb"},  32'(strb()), 32'(exp_strb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; opc = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    chk_st("reset", 3'd0, ST_NONE);
    chk("reset.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_st("idle_hold", 3'd0, ST_NONE);

    // R-type, no waits
    en = 1'b1; opc = OPC_RTYPE; mem_ready = 1'b1;
    step(); chk_st("r.fetch", 3'd1, ST_FETCH_RDY);
    step(); chk_st("r.decode", 3'd2, ST_NONE);
    step(); chk_st("r.exec", 3'd3, ST_EXEC_R);
    step(); chk_st("r.wb", 3'd5, ST_WB_R);
    step(); chk_st("ld.fetch", 3'd1, ST_FETCH_RDY);

    // Load with two MEM wait cycles
    t0 = cyc; opc = OPC_LOAD;
    step(); chk_st("ld.decode", 3'd2, ST_NONE);
    step(); chk_st("ld.exec", 3'd3, ST_EXEC_LS);
    mem_ready = 1'b0;
    step(); chk_st("ld.mem0", 3'd4, ST_MEM_LD);
    step(); chk_st("ld.mem1", 3'd4, ST_MEM_LD);
    step(); chk_st("ld.mem2", 3'd4, ST_MEM_LD);
    mem_ready = 1'b1;
    step(); chk_st("ld.wb", 3'd5, ST_WB_LD);
    chk("ld.cycles", 32'(cyc - t0 + 1), 32'd7);

    // Branch, zero toggled within EXEC
    opc = OPC_BRANCH; zero = 1'b1;
    step(); chk_st("br.fetch", 3'd1, ST_FETCH_RDY);
    step(); chk_st("br.decode", 3'd2, ST_NONE);
    step(); chk_st("br.exec_z1", 3'd3, ST_EXEC_BR1);
    zero = 1'b0; #1;
    chk_st("br.exec_z0", 3'd3, ST_EXEC_BR0);
    step(); chk_st("st.fetch", 3'd1, ST_FETCH_RDY);

    // Store with en dropped mid-instruction: completes, then idles
    opc = OPC_STORE;
    step(); chk_st("st.decode", 3'd2, ST_NONE);
    en = 1'b0;
    step(); chk_st("st.exec", 3'd3, ST_EXEC_LS);
    step(); chk_st("st.mem", 3'd4, ST_MEM_ST);
    step(); chk_st("st.end_idle", 3'd0, ST_NONE);

    // Store interrupted by reset during a MEM wait
    en = 1'b1; mem_ready = 1'b0;
    step(); chk_st("rs.fetch_wait", 3'd1, ST_FETCH_WT);
    step(); chk_st("rs.fetch_wait2", 3'd1, ST_FETCH_WT);
    mem_ready = 1'b1;
    step(); chk_st("rs.decode", 3'd2, ST_NONE);
    step(); chk_st("rs.exec", 3'd3, ST_EXEC_LS);
    mem_ready = 1'b0;
    step(); chk_st("rs.mem", 3'd4, ST_MEM_ST);
    #2 rst_n = 1'b0;
    #1 chk_st("rs.async", 3'd0, ST_NONE);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode: halt and hold despite en/mem_ready
    opc = 7'h7F; mem_ready = 1'b1; en = 1'b1;
    step(); chk_st("il.fetch", 3'd1, ST_FETCH_RDY);
    step(); chk_st("il.decode", 3'd2, ST_NONE);
    chk("il.pre", 32'(illegal), 32'd0);
    step(); chk_st("il.halt", 3'd6, ST_NONE);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("il.hold", {20'd0, state, illegal, strb()}, {20'd0, 3'd6, 1'b1, ST_NONE});
    end
    rst_n = 1'b0;
    #1 chk("il.reset_clr", 32'(illegal), 32'd0);
    chk("il.reset_state", 32'(state), 32'd0);

`ifdef MC_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b1;
    chk("cnt.reset", 32'(instr_cnt), 32'd0);
    opc = OPC_BRANCH; en = 1'b1; mem_ready = 1'b1;
    step();
    for (int k = 0; k < 17; k++) begin
      step(); step(); step();
    end
    chk("cnt.wrap17", 32'(instr_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
